// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, fetches over a req/ack imem port,
// and holds the result in the IF/ID register until decode takes it.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_ready,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   output logic [31:0] IF_ID_IR,
   output logic [31:0] IF_ID_NPC,
   output logic [31:0] IF_ID_PC,
   output logic        IF_ID_valid
);

   localparam logic [31:0] STEP = PC_STEP[31:0];

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_pc;
   logic [31:0] r_req_addr;
   logic [31:0] r_ir;
   logic [31:0] r_if_pc;
   logic [31:0] r_if_npc;
   logic        r_valid;

   logic        w_can_issue;
   logic        w_req;
   logic [31:0] w_addr;
   logic [31:0] w_npc;
   logic        w_capture;
   logic        w_unused;

   assign w_unused    = ^branch_target[1:0];
   assign w_can_issue = ~r_valid | id_ready;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_req & ~imem_ack) w_next = S_BUSY;
         end
         S_BUSY: begin
            if (branch_taken)
               w_next = imem_ack ? S_IDLE : S_DROP;
            else if (imem_ack)
               w_next = S_IDLE;
         end
         S_DROP: begin
            if (imem_ack) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // BUSY and DROP keep the original address until the ack arrives
   always_comb begin
      w_req  = 1'b0;
      w_addr = r_pc;
      case (r_state)
         S_IDLE: begin
            w_req  = w_can_issue & ~branch_taken;
            w_addr = r_pc;
         end
         S_BUSY, S_DROP: begin
            w_req  = 1'b1;
            w_addr = r_req_addr;
         end
         default: begin
            w_req  = 1'b0;
            w_addr = r_pc;
         end
      endcase
      if (rst) w_req = 1'b0;
   end

   assign imem_req  = w_req;
   assign imem_addr = w_addr;
   assign w_npc     = w_addr + STEP;

   assign w_capture = ~branch_taken & imem_ack &
                      ((r_state == S_IDLE & w_req) |
                       (r_state == S_BUSY));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= RESET_PC;
         r_req_addr <= RESET_PC;
         r_ir       <= '0;
         r_if_pc    <= '0;
         r_if_npc   <= '0;
         r_valid    <= 1'b0;
      end else begin
         if (branch_taken)
            r_pc <= {branch_target[31:2], 2'b00};
         else if (w_capture)
            r_pc <= w_npc;

         if (r_state == S_IDLE & w_req & ~imem_ack)
            r_req_addr <= r_pc;

         if (w_capture) begin
            r_ir     <= imem_rdata;
            r_if_pc  <= w_addr;
            r_if_npc <= w_npc;
         end

         // redirect flush wins over capture and consumption
         if (branch_taken)
            r_valid <= 1'b0;
         else if (w_capture)
            r_valid <= 1'b1;
         else if (id_ready)
            r_valid <= 1'b0;
      end
   end

   assign IF_ID_IR    = r_ir;
   assign IF_ID_NPC   = r_if_npc;
   assign IF_ID_PC    = r_if_pc;
   assign IF_ID_valid = r_valid;

endmodule
